// File: rtl/phys_pkg.sv
// Shared types and constants for the box-box contact pipeline blocks.
package phys_pkg;

    localparam int NORM_W      = 10;
    localparam int FACE_IDX_W  = 2;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

endpackage

// File: rtl/incident_edge_sched_rr_arbiter.sv
// Round-robin arbiter: searches from ptr_i+1 upward, wrapping modulo NUM_REQ.
module rr_arbiter
    import phys_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    id_o,
    output logic               any_o
);

    always_comb begin
        logic found;
        int   idx;
        found   = 1'b0;
        idx     = 0;
        grant_o = '0;
        id_o    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr_i) + k) % NUM_REQ;
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                id_o         = ID_W'(idx);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/incident_edge_sched.sv
// Shares one incident-edge search engine between NUM_REQ requesters (round-robin).
// Optional engine watchdog and resp_err port: define ICE_TIMEOUT_EN.
module incident_edge_sched
    import phys_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int W       = NORM_W
`ifdef ICE_TIMEOUT_EN
   ,parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*W-1:0]          req_ref_x,
    input  logic [NUM_REQ*W-1:0]          req_ref_y,
    input  logic [NUM_REQ*4*W-1:0]        req_norm_x,
    input  logic [NUM_REQ*4*W-1:0]        req_norm_y,
    output logic                          eng_start,
    output logic signed [W-1:0]           eng_ref_x,
    output logic signed [W-1:0]           eng_ref_y,
    output logic signed [W-1:0]           eng_n0_x,
    output logic signed [W-1:0]           eng_n0_y,
    output logic signed [W-1:0]           eng_n1_x,
    output logic signed [W-1:0]           eng_n1_y,
    output logic signed [W-1:0]           eng_n2_x,
    output logic signed [W-1:0]           eng_n2_y,
    output logic signed [W-1:0]           eng_n3_x,
    output logic signed [W-1:0]           eng_n3_y,
    input  logic                          eng_done,
    input  logic [FACE_IDX_W-1:0]         eng_index,
    input  logic signed [W-1:0]           eng_norm_x,
    input  logic signed [W-1:0]           eng_norm_y,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [$clog2(NUM_REQ)-1:0]    resp_id,
    output logic [FACE_IDX_W-1:0]         resp_index,
    output logic signed [W-1:0]           resp_norm_x,
    output logic signed [W-1:0]           resp_norm_y
`ifdef ICE_TIMEOUT_EN
   ,output logic                          resp_err
`endif
);

    localparam int ID_W = $clog2(NUM_REQ);

    state_e                  state_q, state_d;
    logic [NUM_REQ-1:0]      gnt;
    logic [ID_W-1:0]         gnt_id;
    logic                    any_req;
    logic                    accept;
    logic [ID_W-1:0]         last_q;
    logic [ID_W-1:0]         id_q;
    logic signed [W-1:0]     ref_x_q, ref_y_q;
    logic signed [W-1:0]     nx_q [4];
    logic signed [W-1:0]     ny_q [4];
    logic [FACE_IDX_W-1:0]   idx_q;
    logic signed [W-1:0]     rnx_q, rny_q;
    logic                    timeout_hit;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_i   (req_valid),
        .ptr_i   (last_q),
        .grant_o (gnt),
        .id_o    (gnt_id),
        .any_o   (any_req)
    );

    assign accept = (state_q == ST_IDLE) && any_req;

`ifdef ICE_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 4) ? $clog2(TIMEOUT_CYCLES) : 4;
    logic [CNT_W-1:0] wd_q;
    logic             err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    wd_q <= '0;
        else if (state_q == ST_WAIT) wd_q <= wd_q + 1'b1;
        else                        wd_q <= '0;
    end

    // A done arriving on the last allowed WAIT cycle still wins over expiry.
    assign timeout_hit = (state_q == ST_WAIT) && !eng_done &&
                         (wd_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign resp_err    = err_q;
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (any_req) state_d = ST_START;
            ST_START:  state_d = ST_WAIT;
            // eng_done is stale before and during START, so it is only trusted here.
            ST_WAIT: begin
                if (eng_done)         state_d = ST_SETTLE;
                else if (timeout_hit) state_d = ST_RESP;
            end
            ST_SETTLE: state_d = ST_RESP;
            ST_RESP:   if (resp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == ST_IDLE && !rst) ? gnt : '0;
        eng_start  = (state_q == ST_START);
        resp_valid = (state_q == ST_RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q  <= ID_W'(NUM_REQ - 1);
            id_q    <= '0;
            ref_x_q <= '0;
            ref_y_q <= '0;
            for (int f = 0; f < 4; f++) begin
                nx_q[f] <= '0;
                ny_q[f] <= '0;
            end
        end else if (accept) begin
            last_q  <= gnt_id;
            id_q    <= gnt_id;
            ref_x_q <= req_ref_x[int'(gnt_id)*W +: W];
            ref_y_q <= req_ref_y[int'(gnt_id)*W +: W];
            for (int f = 0; f < 4; f++) begin
                nx_q[f] <= req_norm_x[(int'(gnt_id)*4 + f)*W +: W];
                ny_q[f] <= req_norm_y[(int'(gnt_id)*4 + f)*W +: W];
            end
        end
    end

    // The engine registers its index one edge after done, so capture in SETTLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
            rnx_q <= '0;
            rny_q <= '0;
`ifdef ICE_TIMEOUT_EN
            err_q <= 1'b0;
`endif
        end else if (state_q == ST_SETTLE) begin
            idx_q <= eng_index;
            rnx_q <= eng_norm_x;
            rny_q <= eng_norm_y;
`ifdef ICE_TIMEOUT_EN
            err_q <= 1'b0;
`endif
        end else if (timeout_hit) begin
            idx_q <= '0;
            rnx_q <= '0;
            rny_q <= '0;
`ifdef ICE_TIMEOUT_EN
            err_q <= 1'b1;
`endif
        end
    end

    assign eng_ref_x   = ref_x_q;
    assign eng_ref_y   = ref_y_q;
    assign eng_n0_x    = nx_q[0];
    assign eng_n0_y    = ny_q[0];
    assign eng_n1_x    = nx_q[1];
    assign eng_n1_y    = ny_q[1];
    assign eng_n2_x    = nx_q[2];
    assign eng_n2_y    = ny_q[2];
    assign eng_n3_x    = nx_q[3];
    assign eng_n3_y    = ny_q[3];
    assign resp_id     = id_q;
    assign resp_index  = idx_q;
    assign resp_norm_x = rnx_q;
    assign resp_norm_y = rny_q;

endmodule
